// File: rtl/video_pos_tracker_if.sv
// Pixel-stream bus between the VDP source (master) and the position tracker (slave).
// Inputs carry the raw strobe/blanking/colour; outputs carry framebuffer coordinates and frame size.
interface video_pos_tracker_if #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int COLOR_BITS = 4
);
  logic                      ce_pix;
  logic                      hblank;
  logic                      vblank;
  logic [COLOR_BITS-1:0]     r_in;
  logic [COLOR_BITS-1:0]     g_in;
  logic [COLOR_BITS-1:0]     b_in;

  logic                      ce_pix_o;
  logic [COLOR_BITS-1:0]     r;
  logic [COLOR_BITS-1:0]     g;
  logic [COLOR_BITS-1:0]     b;
  logic [$clog2(WIDTH)-1:0]  x;
  logic [$clog2(HEIGHT)-1:0] y;
  logic [10:0]               width;
  logic [9:0]                height;
  logic                      frame_valid;

  modport master (
    output ce_pix, hblank, vblank, r_in, g_in, b_in,
    input  ce_pix_o, r, g, b, x, y, width, height, frame_valid
  );

  modport slave (
    input  ce_pix, hblank, vblank, r_in, g_in, b_in,
    output ce_pix_o, r, g, b, x, y, width, height, frame_valid
  );
endinterface

// File: rtl/video_pos_tracker.sv
// Converts a strobe+blanking pixel stream into framebuffer x/y and measures frame width/height; outputs 1 cycle after ce_pix, no backpressure.
// Define FRAME_STABLE_EN to update width/height only after two consecutive frames measure the same size.
module video_pos_tracker #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int COLOR_BITS = 4
) (
  input  logic               clk,
  input  logic               resetn,
  video_pos_tracker_if.slave vif
);
  localparam int          XW    = $clog2(WIDTH);
  localparam int          YW    = $clog2(HEIGHT);
  localparam logic [10:0] W_MAX = 11'(WIDTH);
  localparam logic [9:0]  H_MAX = 10'(HEIGHT);

  typedef enum logic [1:0] {SYNC_WAIT, LINE, HBL, VBL} state_e;

  state_e                state_q, state_d;
  logic                  hblank_q, vblank_q;
  logic [10:0]           xcnt_q, xcnt_d;
  logic [9:0]            ycnt_q, ycnt_d;
  logic [10:0]           line_w_q, line_w_d;
  logic                  ce_q, ce_d;
  logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [10:0]           width_q, width_d;
  logic [9:0]            height_q, height_d;
  logic                  fv_q, fv_d;
`ifdef FRAME_STABLE_EN
  logic [10:0]           prev_w_q, prev_w_d;
  logic [9:0]            prev_h_q, prev_h_d;
  logic                  prev_vld_q, prev_vld_d;
`endif

  logic        hb_rise, hb_fall, vb_rise, vb_fall, active, pix_en, commit;
  logic [10:0] cand_w;
  logic [9:0]  cand_h;

  always_comb begin
    hb_rise  = vif.hblank & ~hblank_q;
    hb_fall  = ~vif.hblank & hblank_q;
    vb_rise  = vif.vblank & ~vblank_q;
    vb_fall  = ~vif.vblank & vblank_q;
    active   = vif.ce_pix & ~vif.hblank & ~vif.vblank;
    state_d  = state_q;
    xcnt_d   = xcnt_q;
    ycnt_d   = ycnt_q;
    line_w_d = line_w_q;
    ce_d     = 1'b0;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    width_d  = width_q;
    height_d = height_q;
    fv_d     = fv_q;
    pix_en   = 1'b0;
    commit   = 1'b0;
`ifdef FRAME_STABLE_EN
    prev_w_d   = prev_w_q;
    prev_h_d   = prev_h_q;
    prev_vld_d = prev_vld_q;
`endif

    // A pixel arriving on the same cycle as the edge that opens a line belongs to that line.
    case (state_q)
      SYNC_WAIT, VBL: begin
        if (vb_fall) begin
          state_d = LINE;
          xcnt_d  = '0;
          ycnt_d  = '0;
          pix_en  = 1'b1;
        end
      end
      LINE: begin
        if (vb_rise || hb_rise) begin
          if (xcnt_q != '0) begin
            line_w_d = xcnt_q;
            xcnt_d   = '0;
            if (ycnt_q != '1) ycnt_d = ycnt_q + 10'd1;
          end
          state_d = vb_rise ? VBL : HBL;
          commit  = vb_rise;
        end else begin
          pix_en = 1'b1;
        end
      end
      HBL: begin
        if (vb_rise) begin
          state_d = VBL;
          commit  = 1'b1;
        end else if (hb_fall) begin
          state_d = LINE;
          pix_en  = 1'b1;
        end
      end
      default: state_d = SYNC_WAIT;
    endcase

    if (pix_en && active) begin
      if (xcnt_d < W_MAX && ycnt_d < H_MAX) begin
        ce_d = 1'b1;
        r_d  = vif.r_in;
        g_d  = vif.g_in;
        b_d  = vif.b_in;
        x_d  = xcnt_d[XW-1:0];
        y_d  = ycnt_d[YW-1:0];
      end
      if (xcnt_d != '1) xcnt_d = xcnt_d + 11'd1;
    end

    cand_w = (line_w_d > W_MAX) ? W_MAX : line_w_d;
    cand_h = (ycnt_d > H_MAX) ? H_MAX : ycnt_d;
    if (commit && ycnt_d != '0) begin
`ifdef FRAME_STABLE_EN
      if (prev_vld_q && cand_w == prev_w_q && cand_h == prev_h_q) begin
        width_d  = cand_w;
        height_d = cand_h;
        fv_d     = 1'b1;
      end
      prev_w_d   = cand_w;
      prev_h_d   = cand_h;
      prev_vld_d = 1'b1;
`else
      width_d  = cand_w;
      height_d = cand_h;
      fv_d     = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= SYNC_WAIT;
      hblank_q   <= 1'b0;
      vblank_q   <= 1'b0;
      xcnt_q     <= '0;
      ycnt_q     <= '0;
      line_w_q   <= '0;
      ce_q       <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      width_q    <= W_MAX;
      height_q   <= H_MAX;
      fv_q       <= 1'b0;
`ifdef FRAME_STABLE_EN
      prev_w_q   <= '0;
      prev_h_q   <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hblank_q   <= vif.hblank;
      vblank_q   <= vif.vblank;
      xcnt_q     <= xcnt_d;
      ycnt_q     <= ycnt_d;
      line_w_q   <= line_w_d;
      ce_q       <= ce_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      x_q        <= x_d;
      y_q        <= y_d;
      width_q    <= width_d;
      height_q   <= height_d;
      fv_q       <= fv_d;
`ifdef FRAME_STABLE_EN
      prev_w_q   <= prev_w_d;
      prev_h_q   <= prev_h_d;
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  assign vif.ce_pix_o    = ce_q;
  assign vif.r           = r_q;
  assign vif.g           = g_q;
  assign vif.b           = b_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.width       = width_q;
  assign vif.height      = height_q;
  assign vif.frame_valid = fv_q;
endmodule
